// File: rtl/ccip_if_pkg.sv
// Subset of the CCI-P interface types used by the HardCloud MMIO read path.
// Field names and encodings follow the platform ccip_if_pkg.
package ccip_if_pkg;

    typedef logic [8:0]  t_ccip_tid;
    typedef logic [15:0] t_ccip_mmioAddr;
    typedef logic [1:0]  t_ccip_mmioLen;
    typedef logic [63:0] t_ccip_mmioData;

    localparam t_ccip_mmioLen CCIP_MMIOLEN_4B  = 2'b00;
    localparam t_ccip_mmioLen CCIP_MMIOLEN_8B  = 2'b01;
    localparam t_ccip_mmioLen CCIP_MMIOLEN_64B = 2'b10;

    typedef struct packed {
        t_ccip_mmioAddr address;
        t_ccip_mmioLen  length;
        logic           rsvd;
        t_ccip_tid      tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [511:0]        data;
        logic                rspValid;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        t_ccip_mmioData      data;
    } t_if_ccip_c2_Tx;

endpackage

// File: rtl/hc_mmio_rd_responder_pkg.sv
// Shared HardCloud CSR map: byte offsets, buffer descriptor types and the
// MMIO read-side register selector.
package hc_mmio_rd_responder_pkg;

    localparam int HC_BUFFER_SIZE = 2;

    localparam logic [15:0] HC_DFH         = 16'h000;
    localparam logic [15:0] HC_AFU_ID_L    = 16'h008;
    localparam logic [15:0] HC_AFU_ID_H    = 16'h010;
    localparam logic [15:0] HC_DSM_BASE    = 16'h110;
    localparam logic [15:0] HC_CONTROL     = 16'h118;
    localparam logic [15:0] HC_BUFFER_BASE = 16'h120;
    localparam logic [15:0] HC_STATUS      = 16'h1F0;
    localparam logic [15:0] HC_PERF_CYCLES = 16'h1F8;

    // MMIO space of the AFU ends at dword 'h100 (byte 0x400).
    localparam logic [14:0] HC_MMIO_QW_LIMIT = 15'h080;

    typedef struct packed {
        logic [63:0] address;
        logic [31:0] size;
    } t_hc_buffer;

    typedef t_hc_buffer t_hc_buffer_array [HC_BUFFER_SIZE];

    typedef enum logic [3:0] {
        HC_RD_NONE,
        HC_RD_DFH,
        HC_RD_AFU_ID_L,
        HC_RD_AFU_ID_H,
        HC_RD_DSM_BASE,
        HC_RD_CONTROL,
        HC_RD_BUF_ADDR,
        HC_RD_BUF_SIZE,
        HC_RD_STATUS,
        HC_RD_PERF
    } t_hc_rd_reg;

    typedef struct packed {
        t_hc_rd_reg  reg_sel;
        logic [7:0]  idx;
    } t_hc_rd_sel;

    // Takes the qword address (dword address >> 1); offsets 0x018/0x020 and
    // anything outside the table decode to HC_RD_NONE, which reads as zero.
    function automatic t_hc_rd_sel hc_mmio_rd_sel(input logic [14:0] qw_addr,
                                                  input int unsigned n_buf);
        t_hc_rd_sel  sel;
        logic [15:0] off;
        logic [15:0] rel;
        logic [31:0] buf_end;

        sel.reg_sel = HC_RD_NONE;
        sel.idx     = '0;
        off         = {qw_addr[12:0], 3'b000};
        rel         = off - HC_BUFFER_BASE;
        buf_end     = {16'h0, HC_BUFFER_BASE} + (n_buf << 4);

        if (qw_addr < HC_MMIO_QW_LIMIT) begin
            case (off)
                HC_DFH:         sel.reg_sel = HC_RD_DFH;
                HC_AFU_ID_L:    sel.reg_sel = HC_RD_AFU_ID_L;
                HC_AFU_ID_H:    sel.reg_sel = HC_RD_AFU_ID_H;
                HC_DSM_BASE:    sel.reg_sel = HC_RD_DSM_BASE;
                HC_CONTROL:     sel.reg_sel = HC_RD_CONTROL;
                HC_STATUS:      sel.reg_sel = HC_RD_STATUS;
                HC_PERF_CYCLES: sel.reg_sel = HC_RD_PERF;
                default: begin
                    if ((off >= HC_BUFFER_BASE) && ({16'h0, off} < buf_end)) begin
                        sel.reg_sel = rel[3] ? HC_RD_BUF_SIZE : HC_RD_BUF_ADDR;
                        sel.idx     = 8'(rel >> 4);
                    end
                end
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/hc_mmio_rd_responder_perf.sv
// Free-running 64-bit cycle counter with synchronous clear; clear wins over
// enable and the count wraps naturally at 2^64.
module hc_perf_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    output logic [63:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/hc_mmio_rd_responder.sv
// CCI-P MMIO read responder for HardCloud AFUs: fixed two-cycle pipeline
// answering every c0 MMIO read with exactly one c2 response.
module hc_mmio_rd_responder
    import ccip_if_pkg::*;
    import hc_mmio_rd_responder_pkg::*;
#(
    parameter logic [63:0] AFU_ID_L       = 64'h0,
    parameter logic [63:0] AFU_ID_H       = 64'h0,
    parameter logic [63:0] DFH_VALUE      = 64'h1000_0000_0000_0000,
    parameter int          HC_BUFFER_SIZE = 2
) (
    input  logic           clk,
    input  logic           SoftReset,
    input  t_if_ccip_c0_Rx cp2af_mmio_c0rx,
    input  logic [63:0]    csr_dsm_base,
    input  logic [31:0]    csr_control,
    input  t_hc_buffer     csr_buffer [HC_BUFFER_SIZE],
    input  logic           hc_running,
    input  logic           hc_done,
    input  logic           perf_clear,
    output t_if_ccip_c2_Tx af2cp_mmio_c2tx
);

    t_ccip_c0_ReqMmioHdr rx_hdr;
    logic                unused_rx;

    logic                s1_valid;
    t_ccip_tid           s1_tid;
    t_ccip_mmioAddr      s1_addr;
    t_ccip_mmioLen       s1_len;
    logic [63:0]         s1_perf;

    logic [63:0]         perf_count;
    t_hc_rd_sel          rd_sel;
    logic [63:0]         buf_address;
    logic [31:0]         buf_size;
    logic [63:0]         reg_val;
    logic [63:0]         rsp_data;

    assign rx_hdr    = cp2af_mmio_c0rx.hdr;
    assign unused_rx = ^{cp2af_mmio_c0rx.data, cp2af_mmio_c0rx.rspValid,
                         cp2af_mmio_c0rx.mmioWrValid, rx_hdr.rsvd};

    hc_perf_counter u_perf (
        .clk    (clk),
        .reset  (SoftReset),
        .clear  (perf_clear),
        .enable (hc_running),
        .count  (perf_count)
    );

    // The counter is snapshotted here so the value returned is the one at
    // request capture, even though the counter keeps running.
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            s1_valid <= 1'b0;
            s1_tid   <= '0;
            s1_addr  <= '0;
            s1_len   <= '0;
            s1_perf  <= '0;
        end else begin
            s1_valid <= cp2af_mmio_c0rx.mmioRdValid;
            if (cp2af_mmio_c0rx.mmioRdValid) begin
                s1_tid  <= rx_hdr.tid;
                s1_addr <= rx_hdr.address;
                s1_len  <= rx_hdr.length;
                s1_perf <= perf_count;
            end
        end
    end

    always_comb begin
        rd_sel      = hc_mmio_rd_sel(s1_addr[15:1], HC_BUFFER_SIZE);
        buf_address = '0;
        buf_size    = '0;
        for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
            if (rd_sel.idx == 8'(i)) begin
                buf_address = csr_buffer[i].address;
                buf_size    = csr_buffer[i].size;
            end
        end
    end

    always_comb begin
        reg_val = '0;
        case (rd_sel.reg_sel)
            HC_RD_DFH:      reg_val = DFH_VALUE;
            HC_RD_AFU_ID_L: reg_val = AFU_ID_L;
            HC_RD_AFU_ID_H: reg_val = AFU_ID_H;
            HC_RD_DSM_BASE: reg_val = csr_dsm_base;
            HC_RD_CONTROL:  reg_val = {32'h0, csr_control};
            HC_RD_BUF_ADDR: reg_val = buf_address;
            HC_RD_BUF_SIZE: reg_val = {32'h0, buf_size};
            HC_RD_STATUS:   reg_val = {62'h0, hc_done, hc_running};
            HC_RD_PERF:     reg_val = s1_perf;
            default:        reg_val = '0;
        endcase
    end

    // Dword address bit 0 picks the half for 4B reads; 8B reads ignore it.
    always_comb begin
        if (s1_len == CCIP_MMIOLEN_4B) begin
            rsp_data = {32'h0, s1_addr[0] ? reg_val[63:32] : reg_val[31:0]};
        end else begin
            rsp_data = reg_val;
        end
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            af2cp_mmio_c2tx <= '0;
        end else begin
            af2cp_mmio_c2tx.mmioRdValid <= s1_valid;
            if (s1_valid) begin
                af2cp_mmio_c2tx.hdr.tid <= s1_tid;
                af2cp_mmio_c2tx.data    <= rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_hc_mmio_rd_responder.sv
// Scoreboard bench for hc_mmio_rd_responder: each read pushes its expected
// tid/data/arrival cycle and the negedge monitor checks responses in order.
module tb_hc_mmio_rd_responder;
    import ccip_if_pkg::*;
    import hc_mmio_rd_responder_pkg::*;

    localparam logic [63:0] ID_L = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] DFH  = 64'h1000_0000_0000_0000;

    logic           clk = 1'b0;
    logic           SoftReset;
    t_if_ccip_c0_Rx c0rx;
    logic [63:0]    dsm;
    logic [31:0]    ctrl;
    t_hc_buffer     bufs [HC_BUFFER_SIZE];
    logic           running;
    logic           done;
    logic           perf_clear;
    t_if_ccip_c2_Tx c2tx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    hc_mmio_rd_responder #(
        .AFU_ID_L       (ID_L),
        .AFU_ID_H       (ID_H),
        .DFH_VALUE      (DFH),
        .HC_BUFFER_SIZE (HC_BUFFER_SIZE)
    ) dut (
        .clk             (clk),
        .SoftReset       (SoftReset),
        .cp2af_mmio_c0rx (c0rx),
        .csr_dsm_base    (dsm),
        .csr_control     (ctrl),
        .csr_buffer      (bufs),
        .hc_running      (running),
        .hc_done         (done),
        .perf_clear      (perf_clear),
        .af2cp_mmio_c2tx (c2tx)
    );

    // Response monitor: every valid response must match the oldest expectation.
    always @(negedge clk) begin
        if (c2tx.mmioRdValid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_rsp tid=%0h data=%h required=no response",
                         c2tx.hdr.tid, c2tx.data);
            end else begin
                mon_e = sb.pop_front();
                total++;
                if (c2tx.hdr.tid !== mon_e.tid) begin
                    bad++;
                    $display("[TB] FAIL rsp_tid got=%0h required=%0h", c2tx.hdr.tid, mon_e.tid);
                end
                total++;
                if (c2tx.data !== mon_e.data) begin
                    bad++;
                    $display("[TB] FAIL rsp_data tid=%0h got=%h required=%h",
                             mon_e.tid, c2tx.data, mon_e.data);
                end
                total++;
                if (cyc !== mon_e.due) begin
                    bad++;
                    $display("[TB] FAIL rsp_latency tid=%0h got_cycle=%0d required_cycle=%0d",
                             mon_e.tid, cyc, mon_e.due);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] ref_reg(input logic [15:0] dw);
        int off;
        off = int'(dw >> 1) * 8;
        if (dw >= 16'h0100) return 64'h0;
        case (off)
            'h000:   return DFH;
            'h008:   return ID_L;
            'h010:   return ID_H;
            'h110:   return dsm;
            'h118:   return {32'h0, ctrl};
            'h120:   return bufs[0].address;
            'h128:   return {32'h0, bufs[0].size};
            'h130:   return bufs[1].address;
            'h138:   return {32'h0, bufs[1].size};
            'h1F0:   return {62'h0, done, running};
            default: return 64'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_read(input logic [8:0] tid, input logic [15:0] dw,
                              input logic [1:0] len, input logic [63:0] exp_data);
        c0rx                 = '0;
        c0rx.mmioRdValid     = 1'b1;
        c0rx.hdr.tid         = tid;
        c0rx.hdr.address     = dw;
        c0rx.hdr.length      = len;
        sb.push_back('{tid, exp_data, cyc + 2});
    endtask

    task automatic send_read(input logic [8:0] tid, input logic [15:0] dw,
                             input logic [1:0] len, input logic [63:0] exp_data);
        tick();
        drive_read(tid, dw, len, exp_data);
    endtask

    task automatic wait_drain(input string name);
        tick();
        c0rx = '0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s_drain pending=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        SoftReset = 1'b1;
        repeat (3) tick();
        total++;
        if (c2tx.mmioRdValid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_valid got=%b required=0", c2tx.mmioRdValid);
        end
        total++;
        if (c2tx.hdr.tid !== 9'h0) begin
            bad++;
            $display("[TB] FAIL reset_tid got=%0h required=0", c2tx.hdr.tid);
        end
        total++;
        if (c2tx.data !== 64'h0) begin
            bad++;
            $display("[TB] FAIL reset_data got=%h required=0", c2tx.data);
        end
        SoftReset = 1'b0;
        send_read(9'h0E, 16'h007E, CCIP_MMIOLEN_8B, 64'h0);
        wait_drain("reset_counter");
    endtask

    task automatic test_id_read();
        send_read(9'h05, 16'h0002, CCIP_MMIOLEN_8B, ID_L);
        send_read(9'h06, 16'h0004, CCIP_MMIOLEN_8B, ID_H);
        wait_drain("id_read");
    endtask

    task automatic test_csr_reads();
        bufs[1].size = 32'h0000_4000;
        dsm          = 64'h1234_5678_9ABC_DEF0;
        send_read(9'h11, 16'h004E, CCIP_MMIOLEN_8B, 64'h0000_0000_0000_4000);
        send_read(9'h12, 16'h0045, CCIP_MMIOLEN_4B, 64'h0000_0000_1234_5678);
        send_read(9'h13, 16'h0044, CCIP_MMIOLEN_4B, 64'h0000_0000_9ABC_DEF0);
        send_read(9'h14, 16'h0045, CCIP_MMIOLEN_8B, 64'h1234_5678_9ABC_DEF0);
        wait_drain("csr_reads");
    endtask

    task automatic test_back_to_back();
        send_read(9'h01, 16'h0000, CCIP_MMIOLEN_8B, DFH);
        send_read(9'h02, 16'h0044, CCIP_MMIOLEN_8B, dsm);
        send_read(9'h03, 16'h00C0, CCIP_MMIOLEN_8B, 64'h0);
        wait_drain("back_to_back");
    endtask

    task automatic test_reg_map();
        logic [15:0] dws [16];
        dws = '{16'h0000, 16'h0006, 16'h0008, 16'h0044, 16'h0046, 16'h0048,
                16'h004A, 16'h004C, 16'h004E, 16'h0050, 16'h007C, 16'h00FC,
                16'h0102, 16'h017E, 16'h0005, 16'h0049};
        ctrl          = 32'hA5C3_0F1E;
        bufs[0]       = '{address: 64'h0000_7F00_1000_0000, size: 32'h0001_0000};
        bufs[1]       = '{address: 64'h0000_7F00_2000_0040, size: 32'h0000_0800};
        done          = 1'b1;
        running       = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_read(9'(9'h40 + i), dws[i], CCIP_MMIOLEN_8B, ref_reg(dws[i]));
        end
        send_read(9'h60, 16'h0046, CCIP_MMIOLEN_4B, {32'h0, ref_reg(16'h0046)[31:0]});
        send_read(9'h61, 16'h004D, CCIP_MMIOLEN_4B, {32'h0, ref_reg(16'h004C)[63:32]});
        send_read(9'h62, 16'h0048, CCIP_MMIOLEN_4B, {32'h0, ref_reg(16'h0048)[31:0]});
        wait_drain("reg_map");
        done = 1'b0;
    endtask

    task automatic test_perf_counter();
        tick();
        perf_clear = 1'b1;
        running    = 1'b0;
        tick();
        perf_clear = 1'b0;
        running    = 1'b1;
        repeat (100) tick();
        running = 1'b0;
        send_read(9'h20, 16'h007E, CCIP_MMIOLEN_8B, 64'd100);
        send_read(9'h21, 16'h007E, CCIP_MMIOLEN_4B, 64'd100);
        wait_drain("perf_100");

        // Counter restarts in the same cycle as the read; response is the snapshot.
        tick();
        drive_read(9'h22, 16'h007E, CCIP_MMIOLEN_8B, 64'd100);
        running = 1'b1;
        tick();
        c0rx = '0;
        repeat (5) tick();
        running = 1'b0;
        wait_drain("perf_snapshot");

        tick();
        perf_clear = 1'b1;
        running    = 1'b1;
        tick();
        perf_clear = 1'b0;
        running    = 1'b0;
        send_read(9'h23, 16'h007E, CCIP_MMIOLEN_8B, 64'd0);
        wait_drain("perf_clear_priority");
    endtask

    task automatic test_reset_midflight();
        tick();
        c0rx             = '0;
        c0rx.mmioRdValid = 1'b1;
        c0rx.hdr.tid     = 9'h1A;
        c0rx.hdr.address = 16'h0002;
        c0rx.hdr.length  = CCIP_MMIOLEN_8B;
        tick();
        c0rx      = '0;
        SoftReset = 1'b1;
        repeat (3) begin
            tick();
            total++;
            if (c2tx.mmioRdValid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL midflight_no_rsp got=%b required=0", c2tx.mmioRdValid);
            end
        end
        SoftReset = 1'b0;
        send_read(9'h1B, 16'h0002, CCIP_MMIOLEN_8B, ID_L);
        wait_drain("after_reset");
    endtask

    task automatic test_write_ignored();
        tick();
        c0rx              = '0;
        c0rx.mmioWrValid  = 1'b1;
        c0rx.hdr.tid      = 9'h2A;
        c0rx.hdr.address  = 16'h0046;
        c0rx.hdr.length   = CCIP_MMIOLEN_8B;
        c0rx.data[63:0]   = 64'hFFFF_0000_FFFF_0000;
        tick();
        c0rx = '0;
        repeat (4) begin
            total++;
            if (c2tx.mmioRdValid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL write_no_rsp got=%b required=0", c2tx.mmioRdValid);
            end
            tick();
        end
    endtask

    initial begin
        SoftReset  = 1'b1;
        c0rx       = '0;
        dsm        = 64'h0;
        ctrl       = 32'h0;
        bufs[0]    = '0;
        bufs[1]    = '0;
        running    = 1'b0;
        done       = 1'b0;
        perf_clear = 1'b0;

        $display("[TB] test_reset");
        test_reset();
        $display("[TB] test_id_read");
        test_id_read();
        $display("[TB] test_csr_reads");
        test_csr_reads();
        $display("[TB] test_back_to_back");
        test_back_to_back();
        $display("[TB] test_reg_map");
        test_reg_map();
        $display("[TB] test_perf_counter");
        test_perf_counter();
        $display("[TB] test_reset_midflight");
        test_reset_midflight();
        $display("[TB] test_write_ignored");
        test_write_ignored();

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
